// File: rtl/thresh_ctr_pkg.sv
// Shared types and constants for the threshold/recover counter block.
package thresh_ctr_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int WRAP_W   = 8;
    localparam int WRAP_MAX = 255;

endpackage

// File: rtl/thresh_recover_ctr_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; used for the recovery tally.
module sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (inc && (r_value != MAX)) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/thresh_recover_ctr.sv
// Counter that accepts increments up to THRESHOLD+1, then spends one HOLD cycle clearing itself.
// Optional embedded assertions are enabled by defining THRESH_CTR_SVA_EN.
//
//   state | meaning
//   RUN   | counting; moves to HOLD on the cycle after count first exceeds THRESHOLD
//   HOLD  | recovery; count forced to 0 and return to RUN on the next edge
module thresh_recover_ctr
    import thresh_ctr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int THRESHOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic              inc_ready_o,
    output logic [WIDTH-1:0]  count_o,
    output logic              over_o,
    output logic              busy_o,
    output logic [WRAP_W-1:0] wrap_cnt_o
);

    // THRESHOLD+1 must be representable so the count can never wrap.
    if (THRESHOLD >= (2 ** WIDTH) - 1) begin : g_bad_threshold
        $error("thresh_recover_ctr: THRESHOLD must be below 2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] TH_W = WIDTH'(THRESHOLD);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_over_raw;
    logic             w_wrap_inc;
    logic             w_ready_run;

    assign w_over_raw  = (r_count > TH_W);
    assign w_ready_run = (r_state == RUN) && !w_over_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wrap_inc  = 1'b0;
        if (clr_i) begin
            w_state_nxt = RUN;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_over_raw) begin
                        w_state_nxt = HOLD;
                        w_wrap_inc  = 1'b1;
                    end else if (inc_i) begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end
                HOLD: begin
                    w_state_nxt = RUN;
                    w_count_nxt = '0;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (WRAP_W),
        .MAX   (WRAP_W'(WRAP_MAX))
    ) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wrap_inc),
        .value (wrap_cnt_o)
    );

    // While in reset the block presents its reset state: RUN with count 0.
    assign inc_ready_o = !clr_i && (!rst_n || w_ready_run);
    assign count_o     = r_count;
    assign over_o      = rst_n && w_over_raw;
    assign busy_o      = rst_n && (r_state == HOLD);

`ifdef THRESH_CTR_SVA_EN
    // Anchored on the first over cycle; HOLD still shows the old count and clr_i overrides recovery.
    a_recover_latency: assert property (@(posedge clk) disable iff (!rst_n)
        (count_o > TH_W) && !busy_o && !clr_i |-> ##2 (count_o == '0))
        else $error("a_recover_latency: count_o not 0 two cycles after exceeding THRESHOLD");

    a_drop_no_queue: assert property (@(posedge clk) disable iff (!rst_n)
        (inc_i && !inc_ready_o) |=> ($stable(count_o) || (count_o == '0)))
        else $error("a_drop_no_queue: dropped increment changed count_o");
`endif

endmodule

// File: tb/tb_thresh_recover_ctr.sv
// Self-checking bench for thresh_recover_ctr: directed table, corner sequences, random vs model.
module tb_thresh_recover_ctr;

    localparam int W  = 4;
    localparam int TH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inc_i = 1'b0;
    logic         clr_i = 1'b0;
    logic         inc_ready_o;
    logic [W-1:0] count_o;
    logic         over_o;
    logic         busy_o;
    logic [7:0]   wrap_cnt_o;

    int total = 0;
    int bad   = 0;

    // reference model state: current count, recovering flag, recovery tally
    int m_count = 0;
    bit m_rec   = 1'b0;
    int m_wrap  = 0;

    always #5 clk = ~clk;

    thresh_recover_ctr #(.WIDTH(W), .THRESHOLD(TH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (inc_i),
        .clr_i       (clr_i),
        .inc_ready_o (inc_ready_o),
        .count_o     (count_o),
        .over_o      (over_o),
        .busy_o      (busy_o),
        .wrap_cnt_o  (wrap_cnt_o)
    );

    typedef struct {
        bit rst;
        bit clr;
        bit inc;
        int cnt;
        bit over;
        bit busy;
        bit ready;
        int wrap;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit i);
        @(negedge clk);
        rst_n = r;
        clr_i = c;
        inc_i = i;
        #1;
    endtask

    task automatic check_model(input string tag);
        bit e_ready;
        e_ready = !rst_n ? !clr_i : (!m_rec && (m_count <= TH) && !clr_i);
        chk({tag, ".ready"}, int'(inc_ready_o), int'(e_ready));
        chk({tag, ".over"},  int'(over_o), (rst_n && m_count > TH) ? 1 : 0);
        chk({tag, ".busy"},  int'(busy_o), (rst_n && m_rec) ? 1 : 0);
        if (rst_n) chk({tag, ".count"}, int'(count_o), m_count);
        chk({tag, ".wrap"},  int'(wrap_cnt_o), m_wrap);
    endtask

    // advance the model across the coming posedge using the inputs now applied
    task automatic advance();
        if (!rst_n) begin
            m_count = 0; m_rec = 1'b0; m_wrap = 0;
        end else if (clr_i) begin
            m_count = 0; m_rec = 1'b0;
        end else if (m_rec) begin
            m_count = 0; m_rec = 1'b0;
        end else if (m_count > TH) begin
            m_rec  = 1'b1;
            m_wrap = (m_wrap < 255) ? m_wrap + 1 : 255;
        end else if (inc_i) begin
            m_count = m_count + 1;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit i);
        drive(r, c, i);
        check_model(tag);
        advance();
    endtask

    initial begin
        tbl[0] = '{1, 0, 1, 0, 0, 0, 1, 0};
        for (int k = 1; k <= 8; k++) tbl[k] = '{1, 0, 1, k, 0, 0, 1, 0};
        tbl[9]  = '{1, 0, 1, 9, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 9, 1, 1, 0, 1};
        tbl[11] = '{1, 0, 1, 0, 0, 0, 1, 1};
        tbl[12] = '{1, 0, 0, 1, 0, 0, 1, 1};
        tbl[13] = '{1, 1, 1, 1, 0, 0, 0, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 1};

        drive(0, 0, 0); advance();
        step("rst", 0, 1, 1);
        step("rst", 0, 0, 1);

        // directed table: fill to 9, recover while inc held, resume, clr+inc
        for (int n = 0; n < 15; n++) begin
            drive(tbl[n].rst, tbl[n].clr, tbl[n].inc);
            chk($sformatf("tbl%0d.count", n), int'(count_o),     tbl[n].cnt);
            chk($sformatf("tbl%0d.over", n),  int'(over_o),      int'(tbl[n].over));
            chk($sformatf("tbl%0d.busy", n),  int'(busy_o),      int'(tbl[n].busy));
            chk($sformatf("tbl%0d.ready", n), int'(inc_ready_o), int'(tbl[n].ready));
            chk($sformatf("tbl%0d.wrap", n),  int'(wrap_cnt_o),  tbl[n].wrap);
            advance();
        end

        // clr with inc at count 5
        for (int k = 0; k < 5; k++) step("to5", 1, 0, 1);
        drive(1, 1, 1);
        chk("clr5.count_pre", int'(count_o), 5);
        check_model("clr5"); advance();
        drive(1, 0, 0);
        chk("clr5.count_post", int'(count_o), 0);
        chk("clr5.wrap", int'(wrap_cnt_o), 1);
        check_model("clr5b"); advance();

        // clr in the over cycle suppresses recovery
        for (int k = 0; k < 9; k++) step("to9", 1, 0, 1);
        drive(1, 1, 0);
        chk("clr9.over", int'(over_o), 1);
        check_model("clr9"); advance();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0);
            chk("clr9.busy", int'(busy_o), 0);
            chk("clr9.count", int'(count_o), 0);
            chk("clr9.wrap", int'(wrap_cnt_o), 1);
            advance();
        end

        // reset asserted during HOLD
        for (int k = 0; k < 9; k++) step("to9r", 1, 0, 1);
        step("over", 1, 0, 0);
        drive(0, 0, 1);
        chk("rsthold.busy", int'(busy_o), 0);
        chk("rsthold.over", int'(over_o), 0);
        chk("rsthold.ready", int'(inc_ready_o), 1);
        advance();
        drive(1, 0, 0);
        chk("rsthold.count", int'(count_o), 0);
        chk("rsthold.wrap", int'(wrap_cnt_o), 0);
        chk("rsthold.busy2", int'(busy_o), 0);
        advance();

        // saturation: 260 recoveries, 11 cycles each with inc held
        for (int k = 0; k < 260 * 11; k++) step("sat", 1, 0, 1);
        chk("sat.wrap", int'(wrap_cnt_o), 255);
        for (int k = 0; k < 33; k++) step("sat2", 1, 0, 1);
        chk("sat.hold255", int'(wrap_cnt_o), 255);

        // random stimulus against the model
        step("rrst", 0, 0, 0);
        for (int k = 0; k < 1500; k++) begin
            bit r, c, i;
            r = ($urandom_range(0, 39) != 0);
            c = ($urandom_range(0, 7) == 0);
            i = ($urandom_range(0, 3) != 0);
            step("rand", r, c, i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
